// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmit state encoding, frame geometry
// and default timing for a 50 MHz system clock.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_DATA      = 3'd3,
        ST_PARITY    = 3'd4,
        ST_STOP      = 3'd5,
        ST_ACK       = 3'd6,
        ST_WAIT_IDLE = 3'd7
    } ps2_tx_state_e;

    localparam int FRAME_CLOCKS       = 11;
    localparam int DATA_BITS          = 8;
    localparam int INHIBIT_CYCLES_DEF = 5000;
    localparam int TIMEOUT_CYCLES_DEF = 750000;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a PS/2 pad with falling-edge detect taken
// one flop after the synchronized level.
module ps2_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic din_i,
    output logic level_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // Idle PS/2 lines float high, so reset to 1 to avoid a false edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= din_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign level_o = s2_q;
    assign fall_o  = s3_q & ~s2_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send,
// device-clocked frame shift-out, ACK check and bus-idle wait.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    inout  wire        ps2_clock,
    inout  wire        ps2_data
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                             INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic clk_s;
    logic clk_fe;
    logic data_s;
    logic unused_data_fe;

    ps2_tx_state_e state_q;
    ps2_tx_state_e state_d;
    logic [7:0]    tx_q;
    logic [7:0]    tx_d;
    logic          par_q;
    logic          par_d;
    logic [3:0]    bitcnt_q;
    logic [3:0]    bitcnt_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          ack_q;
    logic          ack_d;
    logic          done_ev;
    logic          err_ev;
    logic          on_bus;
    logic [2:0]    bit_idx;

    logic clk_oe_q;
    logic clk_oe_d;
    logic data_oe_q;
    logic data_oe_d;
    logic busy_q;
    logic busy_d;
    logic ready_q;
    logic ready_d;
    logic done_q;
    logic done_d;
    logic err_q;
    logic err_d;

    ps2_sync_edge u_clk_sync (
        .clock   (clock),
        .reset   (reset),
        .din_i   (ps2_clk_in),
        .level_o (clk_s),
        .fall_o  (clk_fe)
    );

    ps2_sync_edge u_data_sync (
        .clock   (clock),
        .reset   (reset),
        .din_i   (ps2_data_in),
        .level_o (data_s),
        .fall_o  (unused_data_fe)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tx_q      <= '0;
            par_q     <= 1'b0;
            bitcnt_q  <= '0;
            cnt_q     <= '0;
            ack_q     <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            par_q     <= par_d;
            bitcnt_q  <= bitcnt_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign on_bus = !(state_q inside {ST_IDLE, ST_INHIBIT});

    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        par_d    = par_q;
        bitcnt_d = bitcnt_q;
        cnt_d    = cnt_q;
        ack_d    = ack_q;
        done_ev  = 1'b0;
        err_ev   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d    = '0;
                bitcnt_d = '0;
                if (tx_valid) begin
                    tx_d    = tx_data;
                    par_d   = odd_parity(tx_data);
                    state_d = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_REQ: begin
                if (clk_fe) begin
                    bitcnt_d = 4'd1;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (clk_fe) begin
                    if (bitcnt_q == 4'(DATA_BITS)) begin
                        state_d = ST_PARITY;
                    end else begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (clk_fe) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (clk_fe) begin
                    ack_d   = data_s;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (ack_q) begin
                    err_ev  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    done_ev = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Watchdog between device clock edges; a finished transfer wins.
        if (on_bus) begin
            cnt_d = clk_fe ? '0 : cnt_q + 1'b1;
            if (!clk_fe && cnt_q == TMO_LAST && state_d != ST_IDLE) begin
                err_ev  = 1'b1;
                state_d = ST_IDLE;
            end
        end
    end

    assign bit_idx = bitcnt_d[2:0] - 3'd1;

    always_comb begin
        clk_oe_d  = (state_d == ST_INHIBIT);
        busy_d    = (state_d != ST_IDLE);
        ready_d   = (state_d == ST_IDLE);
        done_d    = done_ev;
        err_d     = err_ev;
        data_oe_d = 1'b0;
        unique case (state_d)
            ST_REQ:    data_oe_d = 1'b1;
            ST_DATA:   data_oe_d = ~tx_q[bit_idx];
            ST_PARITY: data_oe_d = ~par_q;
            default:   data_oe_d = 1'b0;
        endcase
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = busy_q;
    assign tx_ready    = ready_q;
    assign tx_done     = done_q;
    assign tx_error    = err_q;

    assign ps2_clock = ps2_clk_oe  ? 1'b0 : 1'bz;
    assign ps2_data  = ps2_data_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx against a simple PS/2 device model.
// Stimulus queues expected outcomes; a monitor checks them on each pulse.
module tb_ps2_host_tx;

    localparam int INH = 50;
    localparam int TMO = 400;
    localparam int H   = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       tx_done;
    logic       tx_error;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    wire        clk_pad_unused;
    wire        data_pad_unused;
    wire        ps2_clk_in  = ~(dev_clk_low | ps2_clk_oe);
    wire        ps2_data_in = ~(dev_data_low | ps2_data_oe);

    typedef struct {
        bit         err;
        bit         chk_bits;
        logic [9:0] bits;
        bit         chk_gap;
        int         gap;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    int         checks = 0;
    int         errors = 0;
    logic [9:0] cap = '0;
    int         cyc = 0;
    int         oe_run = 0;
    int         inhib_len = 0;
    int         t0 = 0;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .ps2_clock   (clk_pad_unused),
        .ps2_data    (data_pad_unused)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: inhibit length, start bit, and outcome pulses.
    always @(negedge clock) begin
        cyc++;
        if (ps2_clk_oe === 1'b1) begin
            oe_run++;
        end else if (oe_run != 0) begin
            inhib_len = oe_run;
            t0 = cyc;
            oe_run = 0;
            chk("start_bit_with_release", ps2_data_oe, 1);
        end
        if (tx_done === 1'b1 || tx_error === 1'b1) begin
            chk("pulse_exclusive", tx_done & tx_error, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {tx_done, tx_error}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("error_flag", tx_error, e.err);
                chk("done_flag", tx_done, !e.err);
                chk("inhibit_len", inhib_len, INH);
                if (e.chk_bits) chk("frame_bits", cap, e.bits);
                if (e.chk_gap) chk("timeout_gap", cyc - t0, e.gap);
                chk("lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
                chk("ready_after_end", tx_ready, 1);
            end
        end
    end

    task automatic push(input bit err, input bit cb, input logic [9:0] b,
                        input bit cg, input int g);
        exp_t x;
        x.err = err;
        x.chk_bits = cb;
        x.bits = b;
        x.chk_gap = cg;
        x.gap = g;
        exp_q.push_back(x);
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clock);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        chk("accepted", busy, 1);
    endtask

    // Device: waits for request-to-send, then clocks nfe falling edges.
    task automatic device(input bit ack, input int nfe);
        int n = 0;
        while (!(busy === 1'b1 && ps2_clk_oe === 1'b0 &&
                 ps2_data_oe === 1'b1) && n < INH + 20) begin
            @(negedge clock);
            n++;
        end
        chk("request_seen", {busy, ps2_clk_oe, ps2_data_oe}, 3'b101);
        cap = 'x;
        repeat (H) @(negedge clock);
        for (int k = 1; k <= 11 && k <= nfe; k++) begin
            if (k == 11 && ack) begin
                dev_data_low = 1'b1;
                repeat (4) @(negedge clock);
            end
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clock);
            dev_clk_low = 1'b0;
            repeat (H) @(negedge clock);
            if (k <= 10) cap[k-1] = ps2_data_in;
        end
        dev_data_low = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy !== 1'b0 && n < limit) begin
            @(negedge clock);
            n++;
        end
        chk("back_to_idle", busy, 0);
    endtask

    initial begin
        tx_valid = 1'b1;
        tx_data  = 8'h12;
        repeat (3) @(negedge clock);
        chk("rst_ready", tx_ready, 1);
        chk("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {tx_done, tx_error}, 0);
        reset    = 1'b0;
        tx_valid = 1'b0;
        @(negedge clock);
        chk("rst_blocks_accept", {busy, ps2_clk_oe}, 0);

        push(0, 1, 10'h3ED, 0, 0);
        send(8'hED);
        device(1, 11);
        wait_idle(100);

        push(0, 1, 10'h201, 0, 0);
        send(8'h01);
        device(1, 11);
        wait_idle(100);

        push(0, 1, 10'h3FF, 0, 0);
        send(8'hFF);
        device(1, 11);
        wait_idle(100);

        push(0, 1, 10'h3ED, 0, 0);
        send(8'hED);
        fork
            device(1, 11);
            begin
                repeat (30) begin
                    @(negedge clock);
                    tx_data  = 8'h55;
                    tx_valid = ~tx_valid;
                end
                tx_valid = 1'b0;
            end
        join
        wait_idle(100);
        repeat (20) @(negedge clock);
        chk("no_second_xfer", {busy, ps2_clk_oe}, 0);

        push(1, 1, 10'h3AA, 0, 0);
        send(8'hAA);
        device(0, 11);
        wait_idle(100);

        push(1, 0, 10'h000, 1, TMO);
        send(8'h01);
        wait_idle(INH + TMO + 50);

        send(8'hF4);
        device(1, 4);
        repeat (6) @(negedge clock);
        chk("pre_rst_data_oe", ps2_data_oe, 1);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mid_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ready", tx_ready, 1);
        chk("rst_mid_pulses", {tx_done, tx_error}, 0);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        push(0, 1, 10'h2F4, 0, 0);
        send(8'hF4);
        device(1, 11);
        wait_idle(100);

        repeat (10) @(negedge clock);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
